// File: rtl/genius_pkg.sv
// Shared definitions for the genius "desafio" game: state codes and the
// width of the db_estado debug bus (also consumed by the HEX decoder).
package genius_pkg;

    localparam int DB_ESTADO_W = 4;

    typedef enum logic [DB_ESTADO_W-1:0] {
        INICIAL     = 4'd0,
        PREPARA     = 4'd1,
        ESPERA      = 4'd2,
        COMPARA     = 4'd3,
        ESPERA_NOVA = 4'd4,
        GRAVA       = 4'd5,
        FIM_GANHOU  = 4'd6,
        FIM_PERDEU  = 4'd7,
        FIM_TIMEOUT = 4'd8
    } estado_t;

endpackage

// File: rtl/genius_detector_jogada.sv
// Move detector: registered rising-edge detector on "any button pressed",
// captures the button pattern on that edge and flags whether it is one-hot.
// Holding one button and adding another produces no new edge, so it is
// not a new move; all buttons must be released to re-arm.
module genius_detector_jogada
    import genius_pkg::*;
#(
    parameter int N_BOTOES = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    output logic                tem_jogada,
    output logic [N_BOTOES-1:0] jogada,
    output logic                jogada_valida
);

    logic pressionado_q;
    logic borda;

    assign borda = (|botoes) & ~pressionado_q;

    // Edge register, one-cycle move pulse and move capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pressionado_q <= 1'b0;
            tem_jogada    <= 1'b0;
            jogada        <= '0;
            jogada_valida <= 1'b0;
        end else begin
            pressionado_q <= |botoes;
            tem_jogada    <= borda;
            if (borda) begin
                jogada        <= botoes;
                jogada_valida <= ($countones(botoes) == 1);
            end
        end
    end

endmodule

// File: rtl/genius_desafio_param.sv
// Parametrised "desafio" memory game. The player repeats the stored
// sequence, then appends one new move per round, until N_RODADAS rounds
// are completed (win), a wrong move is made (lose) or, when built with
// TIMEOUT_EN, no move arrives within TIMEOUT_CICLOS cycles (timeout).
module genius_desafio_param
    import genius_pkg::*;
#(
    parameter int                  N_BOTOES        = 4,
    parameter int                  N_RODADAS       = 16,
    parameter logic [N_BOTOES-1:0] PRIMEIRA_JOGADA = 4'b0001,
    parameter int                  TIMEOUT_CICLOS  = 30000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         iniciar,
    input  logic [N_BOTOES-1:0]          botoes,
    output logic [N_BOTOES-1:0]          leds,
    output logic                         pronto,
    output logic                         ganhou,
    output logic                         perdeu,
    output logic                         db_timeout,
    output logic [$clog2(N_RODADAS):0]   db_rodada,
    output logic [$clog2(N_RODADAS)-1:0] db_jogada,
    output logic [DB_ESTADO_W-1:0]       db_estado
);

    localparam int AW = $clog2(N_RODADAS);
    localparam int RW = AW + 1;

    estado_t               estado;
    logic [RW-1:0]         rodada;
    logic [AW-1:0]         endereco;
    logic [N_BOTOES-1:0]   mem [N_RODADAS];
    logic [N_BOTOES-1:0]   esperado;
    logic                  tem_jogada;
    logic [N_BOTOES-1:0]   jogada;
    logic                  jogada_valida;
    logic                  errou;
    logic                  estouro;

    genius_detector_jogada #(
        .N_BOTOES (N_BOTOES)
    ) u_detector (
        .clock         (clock),
        .reset         (reset),
        .botoes        (botoes),
        .tem_jogada    (tem_jogada),
        .jogada        (jogada),
        .jogada_valida (jogada_valida)
    );

    assign esperado  = mem[endereco];
    assign errou     = (jogada != esperado) || !jogada_valida;
    assign db_rodada = rodada;
    assign db_jogada = endereco;
    assign db_estado = estado;

`ifdef TIMEOUT_EN
    localparam int TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    logic [TW-1:0] timer;

    assign estouro = (timer == TW'(TIMEOUT_CICLOS - 1));

    // Inter-move timer: runs only while waiting, restarts on every accepted move
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if ((estado == ESPERA || estado == ESPERA_NOVA) && !tem_jogada) begin
            timer <= timer + TW'(1);
        end else begin
            timer <= '0;
        end
    end
`else
    assign estouro = 1'b0;
`endif

    // Sequence memory: first move preloaded on start, new moves appended at rodada
    always_ff @(posedge clock) begin
        if (estado == PREPARA) begin
            mem[0] <= PRIMEIRA_JOGADA;
        end else if (estado == GRAVA && jogada_valida) begin
            mem[rodada[AW-1:0]] <= jogada;
        end
    end

    // Game FSM with registered end flags and LED echo
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado     <= INICIAL;
            rodada     <= '0;
            endereco   <= '0;
            leds       <= '0;
            pronto     <= 1'b0;
            ganhou     <= 1'b0;
            perdeu     <= 1'b0;
            db_timeout <= 1'b0;
        end else begin
            case (estado)
                INICIAL: begin
                    leds <= '0;
                    if (iniciar) estado <= PREPARA;
                end
                PREPARA: begin
                    leds     <= '0;
                    rodada   <= RW'(1);
                    endereco <= '0;
                    estado   <= ESPERA;
                end
                ESPERA, ESPERA_NOVA: begin
                    if (tem_jogada) begin
                        leds   <= jogada;
                        estado <= (estado == ESPERA) ? COMPARA : GRAVA;
                    end else if (estouro) begin
                        pronto     <= 1'b1;
                        perdeu     <= 1'b1;
                        db_timeout <= 1'b1;
                        estado     <= FIM_TIMEOUT;
                    end
                end
                COMPARA: begin
                    if (errou) begin
                        pronto <= 1'b1;
                        perdeu <= 1'b1;
                        estado <= FIM_PERDEU;
                    end else if ({1'b0, endereco} < rodada - RW'(1)) begin
                        endereco <= endereco + AW'(1);
                        estado   <= ESPERA;
                    end else if (rodada == RW'(N_RODADAS)) begin
                        pronto <= 1'b1;
                        ganhou <= 1'b1;
                        estado <= FIM_GANHOU;
                    end else begin
                        estado <= ESPERA_NOVA;
                    end
                end
                GRAVA: begin
                    if (!jogada_valida) begin
                        pronto <= 1'b1;
                        perdeu <= 1'b1;
                        estado <= FIM_PERDEU;
                    end else begin
                        rodada   <= rodada + RW'(1);
                        endereco <= '0;
                        estado   <= ESPERA;
                    end
                end
                FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: begin
                    // flags drop together with leaving the end state
                    if (iniciar) begin
                        pronto     <= 1'b0;
                        ganhou     <= 1'b0;
                        perdeu     <= 1'b0;
                        db_timeout <= 1'b0;
                        estado     <= PREPARA;
                    end
                end
                default: estado <= INICIAL;
            endcase
        end
    end

endmodule

// File: tb/tb_genius_desafio_param.sv
// Self-checking bench for genius_desafio_param (4 buttons, 4 rounds).
// Build with +define+TIMEOUT_EN to exercise the timeout path.
module tb_genius_desafio_param;
    import genius_pkg::*;

    localparam int NB = 4;
    localparam int NR = 4;
    localparam int TO = 50;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          iniciar = 1'b0;
    logic [NB-1:0] botoes = '0;
    logic [NB-1:0] leds;
    logic          pronto, ganhou, perdeu, db_timeout;
    logic [2:0]    db_rodada;
    logic [1:0]    db_jogada;
    logic [3:0]    db_estado;

    genius_desafio_param #(
        .N_BOTOES        (NB),
        .N_RODADAS       (NR),
        .PRIMEIRA_JOGADA (4'b0001),
        .TIMEOUT_CICLOS  (TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .iniciar    (iniciar),
        .botoes     (botoes),
        .leds       (leds),
        .pronto     (pronto),
        .ganhou     (ganhou),
        .perdeu     (perdeu),
        .db_timeout (db_timeout),
        .db_rodada  (db_rodada),
        .db_jogada  (db_jogada),
        .db_estado  (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      tag;
        logic [3:0] estado;
        int         rodada;
        int         jogada;
        logic [3:0] leds;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic [3:0] seq [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic esperar(input string tag, input logic [3:0] e, input int r, input int j,
                           input logic [3:0] l);
        exp_t x;
        x.tag = tag; x.estado = e; x.rodada = r; x.jogada = j; x.leds = l;
        sb.push_back(x);
    endtask

    task automatic conferir();
        exp_t x;
        logic fim;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'(sb.size()), 32'd1);
            return;
        end
        x = sb.pop_front();
        fim = (x.estado == FIM_GANHOU) || (x.estado == FIM_PERDEU) || (x.estado == FIM_TIMEOUT);
        check({x.tag, ".estado"},  32'(db_estado),  32'(x.estado));
        check({x.tag, ".rodada"},  32'(db_rodada),  32'(x.rodada));
        check({x.tag, ".jogada"},  32'(db_jogada),  32'(x.jogada));
        check({x.tag, ".leds"},    32'(leds),       32'(x.leds));
        check({x.tag, ".pronto"},  32'(pronto),     32'(fim));
        check({x.tag, ".ganhou"},  32'(ganhou),     32'(x.estado == FIM_GANHOU));
        check({x.tag, ".perdeu"},  32'(perdeu),     32'(x.estado == FIM_PERDEU || x.estado == FIM_TIMEOUT));
        check({x.tag, ".timeout"}, 32'(db_timeout), 32'(x.estado == FIM_TIMEOUT));
    endtask

    // press edge + 2 cycles to verdict, then release and let the detector re-arm
    task automatic press(input string tag, input logic [3:0] m, input logic [3:0] e,
                         input int r, input int j, input logic [3:0] l);
        @(negedge clock) botoes = m;
        esperar(tag, e, r, j, l);
        repeat (3) @(posedge clock);
        @(negedge clock);
        conferir();
        botoes = '0;
        repeat (2) @(negedge clock);
    endtask

    task automatic pulso_iniciar();
        @(negedge clock) iniciar = 1'b1;
        @(posedge clock);
        @(negedge clock) iniciar = 1'b0;
    endtask

    task automatic iniciar_jogo(input string tag);
        pulso_iniciar();
        @(negedge clock);
        esperar(tag, ESPERA, 1, 0, 4'b0000);
        conferir();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        seq[0] = 4'b0001; seq[1] = 4'b0100; seq[2] = 4'b1000; seq[3] = 4'b0010;

        // T1: reset values, then long iniciar
        #3 reset = 1'b1;
        #2;
        esperar("reset", INICIAL, 0, 0, 4'b0000);
        conferir();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock) iniciar = 1'b1;
        repeat (10) @(posedge clock);
        @(negedge clock) iniciar = 1'b0;
        esperar("t1_start", ESPERA, 1, 0, 4'b0000);
        conferir();

        // T2: wrong move in round 2
        press("t2_r1",     4'b0001, ESPERA_NOVA, 1, 0, 4'b0001);
        press("t2_new",    4'b0100, ESPERA,      2, 0, 4'b0100);
        press("t2_r2_0",   4'b0001, ESPERA,      2, 1, 4'b0001);
        press("t2_r2_bad", 4'b0010, FIM_PERDEU,  2, 1, 4'b0010);

        // T3: full correct game to the win
        iniciar_jogo("t3_start");
        for (int r = 1; r <= NR; r++) begin
            for (int i = 0; i < r; i++) begin
                if (i < r - 1)
                    press("t3_rep", seq[i], ESPERA, r, i + 1, seq[i]);
                else if (r == NR)
                    press("t3_win", seq[i], FIM_GANHOU, r, i, seq[i]);
                else
                    press("t3_last", seq[i], ESPERA_NOVA, r, i, seq[i]);
            end
            if (r < NR) press("t3_new", seq[r], ESPERA, r + 1, 0, seq[r]);
        end
        press("t3_hold", 4'b0001, FIM_GANHOU, NR, NR - 1, 4'b0010);

        // T5: added button while held is not a move; two-button new move loses
        iniciar_jogo("t5_start");
        press("t5_r1", 4'b0001, ESPERA_NOVA, 1, 0, 4'b0001);
        @(negedge clock) botoes = 4'b0001;
        @(posedge clock);
        @(negedge clock) botoes = 4'b0011;
        esperar("t5_held", ESPERA, 2, 0, 4'b0001);
        repeat (4) @(posedge clock);
        @(negedge clock);
        conferir();
        botoes = '0;
        repeat (2) @(negedge clock);
        press("t5_r2_0", 4'b0001, ESPERA,      2, 1, 4'b0001);
        press("t5_r2_1", 4'b0001, ESPERA_NOVA, 2, 1, 4'b0001);
        press("t5_dual", 4'b0011, FIM_PERDEU,  2, 1, 4'b0011);

        // T6: iniciar ignored mid-game, reset in round 3 aborts at once
        iniciar_jogo("t6_start");
        press("t6_r1",  4'b0001, ESPERA_NOVA, 1, 0, 4'b0001);
        press("t6_new", 4'b0100, ESPERA,      2, 0, 4'b0100);
        pulso_iniciar();
        repeat (2) @(negedge clock);
        esperar("t6_ignore", ESPERA, 2, 0, 4'b0100);
        conferir();
        press("t6_r2_0",  4'b0001, ESPERA,      2, 1, 4'b0001);
        press("t6_r2_1",  4'b0100, ESPERA_NOVA, 2, 1, 4'b0100);
        press("t6_new2",  4'b1000, ESPERA,      3, 0, 4'b1000);
        @(negedge clock) reset = 1'b1;
        #1;
        esperar("t6_reset", INICIAL, 0, 0, 4'b0000);
        conferir();
        @(negedge clock) reset = 1'b0;
        repeat (2) @(negedge clock);
        esperar("t6_idle", INICIAL, 0, 0, 4'b0000);
        conferir();

        // T4: idle player
        pulso_iniciar();
`ifdef TIMEOUT_EN
        repeat (TO) @(posedge clock);
        @(negedge clock);
        esperar("t4_last_wait", ESPERA, 1, 0, 4'b0000);
        conferir();
        @(posedge clock);
        @(negedge clock);
        esperar("t4_timeout", FIM_TIMEOUT, 1, 0, 4'b0000);
        conferir();
`else
        repeat (1000) @(posedge clock);
        @(negedge clock);
        esperar("t4_no_timeout", ESPERA, 1, 0, 4'b0000);
        conferir();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
